prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 121 ++++++++++++
 tb/tb_prog_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses CORE/ADDR/COUNT headers and writes
// assembled instruction words into the selected core's program memory.
`ifndef CORES
`define CORES 8
`endif
`ifndef LOG_CORES
`define LOG_CORES 3
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 5
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

// state   | meaning
// S_IDLE  | waiting for CORE byte
// S_ADDR  | waiting for start-address byte
// S_COUNT | waiting for word-count (words-1) byte
// S_DATA  | collecting the bytes of one word
// S_WRITE | single-cycle write strobe, stream stalled
module prog_loader (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    we,
  output logic [`LOG_CORES-1:0]   sel,
  output logic [`PC_WIDTH-1:0]    waddr,
  output logic [`INSTR_WIDTH-1:0] wdata,
  output logic                    busy,
  output logic                    done
);
  localparam int IW = `INSTR_WIDTH;
  localparam int IB = (IW + 7) / 8;
  localparam logic [1:0] LAST_BYTE = 2'(IB - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_COUNT, S_DATA, S_WRITE} state_t;

  state_t                  state_q;
  logic [IW-1:0]           acc_q;
  logic [IW-1:0]           acc_d;
  logic [1:0]              byte_cnt_q;
  logic [7:0]              words_q;
  logic                    we_q;
  logic                    done_q;
  logic [`LOG_CORES-1:0]   sel_q;
  logic [`PC_WIDTH-1:0]    waddr_q;
  logic [IW-1:0]           wdata_q;
  logic                    accept;

  assign accept = in_valid & in_ready;
  // Older bytes fall off the top, so no clear is needed between words.
  assign acc_d  = IW'({acc_q, in_data});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      byte_cnt_q <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      sel_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          sel_q   <= in_data[`LOG_CORES-1:0];
          state_q <= S_ADDR;
        end
        S_ADDR: if (accept) begin
          waddr_q <= in_data[`PC_WIDTH-1:0];
          state_q <= S_COUNT;
        end
        S_COUNT: if (accept) begin
          words_q    <= in_data;
          byte_cnt_q <= '0;
          state_q    <= S_DATA;
        end
        S_DATA: if (accept) begin
          acc_q <= acc_d;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_q <= '0;
            wdata_q    <= acc_d;
            we_q       <= 1'b1;
            state_q    <= S_WRITE;
          end else begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        S_WRITE: begin
          we_q    <= 1'b0;
          waddr_q <= waddr_q + 1'b1;
          if (words_q == 8'd0) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            words_q <= words_q - 8'd1;
            state_q <= S_DATA;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Gated by rst_n so the stream is held off during reset and opens the
  // moment reset releases.
  assign in_ready = rst_n & (state_q != S_WRITE);
  assign busy     = (state_q != S_IDLE);
  assign we       = we_q;
  assign done     = done_q;
  assign sel      = sel_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frames push expected writes, a negedge
// monitor pops and compares on every write strobe.
`ifndef CORES
`define CORES 8
`endif
`ifndef LOG_CORES
`define LOG_CORES 3
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 5
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module tb_prog_loader;
  localparam int IW = `INSTR_WIDTH;
  localparam int IB = (IW + 7) / 8;
  localparam int PW = `PC_WIDTH;
  localparam int LC = `LOG_CORES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          we;
  logic [LC-1:0] sel;
  logic [PW-1:0] waddr;
  logic [IW-1:0] wdata;
  logic          busy;
  logic          done;

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .sel(sel), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LC-1:0] sel;
    logic [PW-1:0] waddr;
    logic [IW-1:0] wdata;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            we_cnt = 0;
  int            done_cnt = 0;
  logic          exp_done = 1'b0;
  logic [IW-1:0] held_wdata = '0;
  logic          gaps = 1'b0;
  logic          acc_in_done = 1'b0;
  logic          first_acc_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      exp_done   = 1'b0;
      held_wdata = '0;
    end else begin
      check("in_ready_vs_write", 64'(in_ready), 64'(!we));
      check("done_timing", 64'(done), 64'(exp_done));
      if (done) begin
        done_cnt++;
        check("busy_at_done", 64'(busy), 64'd0);
      end
      exp_done = 1'b0;
      if (we) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_we", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sel", 64'(sel), 64'(e.sel));
          check("waddr", 64'(waddr), 64'(e.waddr));
          check("wdata", 64'(wdata), 64'(e.wdata));
          exp_done = e.last;
        end
        held_wdata = wdata;
      end else begin
        check("wdata_hold", 64'(wdata), 64'(held_wdata));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic rdy;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      rdy         = in_ready;
      acc_in_done = done;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] core, input logic [7:0] addr,
                            input logic [7:0] cnt, input logic [IW-1:0] words[$]);
    exp_t e;
    for (int i = 0; i <= int'(cnt); i++) begin
      e.sel   = core[LC-1:0];
      e.waddr = PW'(int'(addr) + i);
      e.wdata = words[i];
      e.last  = (i == int'(cnt));
      exp_q.push_back(e);
    end
    send_byte(core);
    first_acc_done = acc_in_done;
    send_byte(addr);
    send_byte(cnt);
    for (int i = 0; i <= int'(cnt); i++)
      for (int k = IB - 1; k >= 0; k--)
        send_byte(8'(words[i] >> (8 * k)));
  endtask

  task automatic drain(input string name, input int we0, input int d0, input int nw);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_we_count"}, 64'(we_cnt - we0), 64'(nw));
    check({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_we"}, 64'(we), 64'd0);
    check({name, "_sel"}, 64'(sel), 64'd0);
    check({name, "_waddr"}, 64'(waddr), 64'd0);
    check({name, "_wdata"}, 64'(wdata), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [IW-1:0] w[$];
    int we0, d0;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("in_ready_after_por", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // single word
    we0 = we_cnt; d0 = done_cnt;
    w = '{32'hDEADBEEF};
    send_frame(8'h02, 8'h04, 8'h00, w);
    drain("single", we0, d0, 1);

    // two words wrapping the address
    we0 = we_cnt; d0 = done_cnt;
    w = '{32'h01234567, 32'h89ABCDEF};
    send_frame(8'h07, 8'h1F, 8'h01, w);
    drain("wrap", we0, d0, 2);

    // upper header bits ignored, 256 words
    we0 = we_cnt; d0 = done_cnt;
    w.delete();
    for (int i = 0; i < 256; i++)
      w.push_back({8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3});
    send_frame(8'hF3, 8'hF0, 8'hFF, w);
    drain("max", we0, d0, 256);

    // same frame without and with stream gaps
    w = '{32'h11223344, 32'hA5A55A5A, 32'h0F0F00FF};
    we0 = we_cnt; d0 = done_cnt;
    send_frame(8'h05, 8'h06, 8'h02, w);
    drain("nogap", we0, d0, 3);
    gaps = 1'b1;
    we0 = we_cnt; d0 = done_cnt;
    send_frame(8'h05, 8'h06, 8'h02, w);
    drain("gaps", we0, d0, 3);
    gaps = 1'b0;

    // reset after two data bytes
    we0 = we_cnt;
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'hDE);
    send_byte(8'hAD);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midword_rst");
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("midword_no_we", 64'(we_cnt - we0), 64'd0);
    we0 = we_cnt; d0 = done_cnt;
    w = '{32'hCAFEF00D};
    send_frame(8'h01, 8'h09, 8'h00, w);
    drain("after_rst", we0, d0, 1);

    // back-to-back frames, second CORE byte during the done cycle
    we0 = we_cnt; d0 = done_cnt;
    w = '{32'h00000001, 32'h80000000};
    send_frame(8'h03, 8'h10, 8'h01, w);
    w = '{32'h12345678};
    send_frame(8'h06, 8'h1E, 8'h00, w);
    check("core_in_done_cycle", 64'(first_acc_done), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
    check("b2b_we_count", 64'(we_cnt - we0), 64'd3);
    check("b2b_done_count", 64'(done_cnt - d0), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
